// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: FSM state encoding and saturation-limit helpers shared by the dot_acc block
package dot_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] sat_hi(input int w, input logic s);
        return s ? (MAX_W'(1) << (w - 1)) - MAX_W'(1) : (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    function automatic logic [MAX_W-1:0] sat_lo(input int w, input logic s);
        return s ? MAX_W'(1) << (w - 1) : '0;
    endfunction

endpackage

// File: rtl/dot_acc_if.sv
// dot_acc_if: operand beat stream in, dot-product result stream out
interface dot_acc_if #(
    parameter int A_width   = 16,
    parameter int B_width   = 16,
    parameter int CNT_width = 8
);
    logic                       tc;
    logic                       in_valid;
    logic                       in_ready;
    logic [A_width-1:0]         in_a;
    logic [B_width-1:0]         in_b;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [A_width+B_width-1:0] out_acc;
    logic [CNT_width-1:0]       out_cnt;
    logic                       out_ovf;

    modport master (
        output tc, in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport slave (
        input  tc, in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );
endinterface

// File: rtl/dot_acc_dp.sv
// dot_acc_dp: combinational a*b+c with tc-selected extension and one-bit-wider overflow check
module dot_acc_dp #(
    parameter int A_width = 16,
    parameter int B_width = 16
) (
    input  logic [A_width-1:0]         a_i,
    input  logic [B_width-1:0]         b_i,
    input  logic [A_width+B_width-1:0] c_i,
    input  logic                       tc_i,
    output logic [A_width+B_width-1:0] sum_o,
    output logic                       ovf_o
);
    localparam int W = A_width + B_width;

    logic [W-1:0] ea, eb, prod;
    logic [W:0]   s;

    assign ea    = {{B_width{tc_i & a_i[A_width-1]}}, a_i};
    assign eb    = {{A_width{tc_i & b_i[B_width-1]}}, b_i};
    assign prod  = ea * eb;
    assign s     = {tc_i & prod[W-1], prod} + {tc_i & c_i[W-1], c_i};
    assign sum_o = s[W-1:0];
    assign ovf_o = tc_i ? s[W] ^ s[W-1] : s[W];
endmodule

// File: rtl/dot_acc.sv
// dot_acc: streaming dot-product accumulator; define DOT_ACC_SAT_EN to clamp on overflow instead of wrapping
module dot_acc
    import dot_acc_pkg::*;
#(
    parameter int A_width   = 16,
    parameter int B_width   = 16,
    parameter int CNT_width = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    dot_acc_if.slave bus
);
    localparam int W = A_width + B_width;

    state_e               state_q, state_d;
    logic [W-1:0]         acc_q, acc_d, dp_c, dp_sum, acc_new;
    logic [CNT_width-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, tc_q, tc_d, tc_e, dp_ovf, accept, first;

    assign first  = state_q == IDLE;
    assign accept = bus.in_valid && bus.in_ready;
    assign tc_e   = first ? bus.tc : tc_q;
    assign dp_c   = first ? '0 : acc_q;

    dot_acc_dp #(.A_width(A_width), .B_width(B_width)) u_dp (
        .a_i   (bus.in_a),
        .b_i   (bus.in_b),
        .c_i   (dp_c),
        .tc_i  (tc_e),
        .sum_o (dp_sum),
        .ovf_o (dp_ovf)
    );

`ifdef DOT_ACC_SAT_EN
    // signed overflow can only go the way of the running sum's sign, unsigned only upward
    assign acc_new = !dp_ovf ? dp_sum :
                     (tc_e && dp_c[W-1]) ? W'(sat_lo(W, tc_e)) : W'(sat_hi(W, tc_e));
`else
    assign acc_new = dp_sum;
`endif

    assign bus.in_ready  = state_q != HOLD;
    assign bus.out_valid = state_q == HOLD;
    assign bus.out_acc   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;

    // state and vector registers; reset discards any partial vector
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            tc_q    <= tc_d;
        end
    end

    // a first beat restarts the vector; later beats accumulate; HOLD waits for the consumer
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        tc_d    = tc_q;
        if (accept) begin
            acc_d   = acc_new;
            cnt_d   = first ? CNT_width'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_width'(1));
            ovf_d   = dp_ovf | (ovf_q & ~first);
            tc_d    = tc_e;
            state_d = bus.in_last ? HOLD : ACC;
        end else if (state_q == HOLD && bus.out_ready) begin
            state_d = IDLE;
        end
    end
endmodule
